// File: rtl/block_token_emitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_token_emitter_pkg
// Description : Shared command encodings, ASCII constants, token lengths and
//               FSM state type for block_token_emitter and its token ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package block_token_emitter_pkg;

  // Command codes as presented on the cmd port.
  typedef enum logic [1:0] {
    CMD_BEGIN = 2'd0,
    CMD_END   = 2'd1,
    CMD_FILL  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  localparam int IDX_W = 3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  // Lowercase minus this offset gives the uppercase letter.
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam logic [IDX_W-1:0] LEN_BEGIN = 3'd6;
  localparam logic [IDX_W-1:0] LEN_END   = 3'd4;
  localparam logic [IDX_W-1:0] LEN_FILL  = 3'd2;

  // Number of characters a token occupies, trailing space included.
  function automatic logic [IDX_W-1:0] token_len(input cmd_e tok);
    logic [IDX_W-1:0] len;
    case (tok)
      CMD_BEGIN: len = LEN_BEGIN;
      CMD_END:   len = LEN_END;
      default:   len = LEN_FILL;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_token_emitter_token_rom.sv
`default_nettype none
// ============================================================================
// Module      : token_rom
// Description : Combinational character table. Maps (token, index, case,
//               fill character) to the character at that index and a flag
//               marking the trailing space.
// Ports       : token     in  cmd_e   - latched token
//               idx       in  3       - character index within the token
//               upper     in  1       - 1 = uppercase letters
//               fill_char in  8       - character emitted by FILL, verbatim
//               ch        out 8       - character at idx
//               last      out 1       - idx is the trailing space
// Revision    : 1.0 - initial release
// ============================================================================
module token_rom
  import block_token_emitter_pkg::*;
(
  input  cmd_e             token,
  input  logic [IDX_W-1:0] idx,
  input  logic             upper,
  input  logic [7:0]       fill_char,
  output logic [7:0]       ch,
  output logic             last
);

  logic [7:0] base;
  logic       verbatim;

  always_comb begin
    base     = ASCII_SPACE;
    verbatim = 1'b0;
    case (token)
      CMD_BEGIN: begin
        case (idx)
          3'd0:    base = 8'h62;
          3'd1:    base = 8'h65;
          3'd2:    base = 8'h67;
          3'd3:    base = 8'h69;
          3'd4:    base = 8'h6E;
          default: base = ASCII_SPACE;
        endcase
      end
      CMD_END: begin
        case (idx)
          3'd0:    base = 8'h65;
          3'd1:    base = 8'h6E;
          3'd2:    base = 8'h64;
          default: base = ASCII_SPACE;
        endcase
      end
      CMD_FILL: begin
        if (idx == 3'd0) begin
          base     = fill_char;
          verbatim = 1'b1;
        end
      end
      default: base = ASCII_SPACE;
    endcase

    // Only keyword letters change case; spaces and fill characters pass through.
    if (upper && !verbatim && (base != ASCII_SPACE)) begin
      ch = base - CASE_OFFSET;
    end else begin
      ch = base;
    end

    last = (idx == (token_len(token) - 3'd1));
  end

endmodule
`default_nettype wire

// File: rtl/block_token_emitter.sv
`default_nettype none
// ============================================================================
// Module      : block_token_emitter
// Description : Serialises BEGIN / END / FILL commands as space-terminated
//               ASCII words, one character per cycle, and tracks the nesting
//               depth and verdict a block checker fed this stream would give.
// Ports       : clk        in  1        - clock, rising edge
//               reset      in  1        - synchronous, active-high
//               cmd_valid  in  1        - command presented
//               cmd        in  2        - 0 BEGIN, 1 END, 2 FILL, 3 reserved
//               upper      in  1        - uppercase letters (sampled on accept)
//               fill_char  in  8        - FILL character (sampled on accept)
//               cmd_ready  out 1        - command accepted when valid && ready
//               out        out 8        - emitted character, registered
//               out_valid  out 1        - out carries a token character
//               depth      out DEPTH_W  - current nesting depth
//               balanced   out 1        - depth == 0 and not broken
//               broken     out 1        - sticky nesting error
// Revision    : 1.0 - initial release
// ============================================================================
module block_token_emitter
  import block_token_emitter_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               upper,
  input  logic [7:0]         fill_char,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               broken
);

  state_e             state_q, state_d;
  cmd_e               tok_q, tok_d;
  logic               upper_q, upper_d;
  logic [7:0]         fill_q, fill_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               last_q, last_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               broken_q, broken_d;

  logic               accept;
  logic               start;
  logic               finish;
  logic [7:0]         rom_ch;
  logic               rom_last;

  // last_q is registered alongside out_q and marks that the current idx is
  // the trailing space, so ready depends only on state and index.
  assign cmd_ready = (state_q == S_IDLE) || last_q;

  // The ROM is addressed with the next-cycle token and index so that the
  // character lands in out_q on the same edge that the index advances.
  token_rom u_token_rom (
    .token     (tok_d),
    .idx       (idx_d),
    .upper     (upper_d),
    .fill_char (fill_d),
    .ch        (rom_ch),
    .last      (rom_last)
  );

  always_comb begin
    accept  = cmd_valid && cmd_ready;
    start   = accept && (cmd_e'(cmd) != CMD_RSVD);
    finish  = (state_q == S_EMIT) && last_q;

    state_d  = state_q;
    tok_d    = tok_q;
    upper_d  = upper_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    depth_d  = depth_q;
    broken_d = broken_q;

    if (start) begin
      state_d = S_EMIT;
      tok_d   = cmd_e'(cmd);
      upper_d = upper;
      fill_d  = fill_char;
      idx_d   = '0;
    end else if (finish) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else if (state_q == S_EMIT) begin
      idx_d = idx_q + 3'd1;
    end

    // Depth moves at the edge that ends the trailing-space cycle, even when a
    // new token is accepted on that same edge.
    if (finish) begin
      case (tok_q)
        CMD_BEGIN: begin
          if (depth_q == {DEPTH_W{1'b1}}) begin
            broken_d = 1'b1;
          end else begin
            depth_d = depth_q + 1'b1;
          end
        end
        CMD_END: begin
          if (depth_q == '0) begin
            broken_d = 1'b1;
          end else begin
            depth_d = depth_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    out_valid_d = (state_d == S_EMIT);
    out_d       = (state_d == S_EMIT) ? rom_ch : ASCII_SPACE;
    last_d      = (state_d == S_EMIT) && rom_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tok_q       <= CMD_FILL;
      upper_q     <= 1'b0;
      fill_q      <= ASCII_SPACE;
      idx_q       <= '0;
      out_q       <= ASCII_SPACE;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      depth_q     <= '0;
      broken_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      upper_q     <= upper_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      depth_q     <= depth_d;
      broken_q    <= broken_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign depth     = depth_q;
  assign broken    = broken_q;
  assign balanced  = (depth_q == '0) && !broken_q;

endmodule
`default_nettype wire

// File: tb/tb_block_token_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_token_emitter
// Description : Scoreboard bench for block_token_emitter. A driver issues
//               directed and random commands; a token-level model pushes the
//               expected characters and resulting depth/error state; a
//               monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_token_emitter;

  localparam int DW   = 2;
  localparam int MAXD = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic          upper = 1'b0;
  logic [7:0]    fill_char = 8'h20;
  logic          cmd_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic [DW-1:0] depth;
  logic          balanced;
  logic          broken;

  always #5 clk = ~clk;

  block_token_emitter #(.DEPTH_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .upper     (upper),
    .fill_char (fill_char),
    .cmd_ready (cmd_ready),
    .out       (out),
    .out_valid (out_valid),
    .depth     (depth),
    .balanced  (balanced),
    .broken    (broken)
  );

  typedef struct {
    logic [7:0] ch;
    bit         last;
    int         d;
    bit         br;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_depth = 0;
  bit   m_broken = 1'b0;
  bit   mon_en = 1'b0;
  bit   pend = 1'b0;
  int   pend_d = 0;
  bit   pend_br = 1'b0;
  exp_t e_mon;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Token-level reference: what the word looks like and what a checker
  // would conclude after reading it.
  task automatic model_accept(input logic [1:0] c, input logic up, input logic [7:0] fc);
    string      s;
    logic [7:0] chars[$];
    logic [7:0] x;
    exp_t       e;
    case (c)
      2'd0: s = "begin ";
      2'd1: s = "end ";
      2'd2: s = "";
      default: return;
    endcase
    if (c == 2'd2) begin
      chars.push_back(fc);
      chars.push_back(8'h20);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        x = s[i];
        if (up && x >= 8'h61 && x <= 8'h7A) x = x - 8'd32;
        chars.push_back(x);
      end
    end
    if (c == 2'd0) begin
      if (m_depth == MAXD) m_broken = 1'b1;
      else m_depth++;
    end else if (c == 2'd1) begin
      if (m_depth == 0) m_broken = 1'b1;
      else m_depth--;
    end
    for (int i = 0; i < chars.size(); i++) begin
      e.ch   = chars[i];
      e.last = (i == chars.size() - 1);
      e.d    = m_depth;
      e.br   = m_broken;
      q.push_back(e);
    end
  endtask

  // Monitor: compares every cycle at the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("depth_after", 32'(depth), 32'(pend_d));
        chk("broken_after", 32'(broken), 32'(pend_br));
        chk("balanced_after", 32'(balanced), 32'((pend_d == 0) && !pend_br));
        pend = 1'b0;
      end
      if (q.size() > 0) begin
        e_mon = q.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_char", 32'(out), 32'(e_mon.ch));
        chk("ready_in_token", 32'(cmd_ready), 32'(e_mon.last));
        if (e_mon.last) begin
          pend    = 1'b1;
          pend_d  = e_mon.d;
          pend_br = e_mon.br;
        end
      end else begin
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_out", 32'(out), 32'h20);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic up, input logic [7:0] fc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    upper     = up;
    fill_char = fc;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(c, up, fc);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending chars expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en    = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    q.delete();
    pend     = 1'b0;
    m_depth  = 0;
    m_broken = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 32'h20);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_broken", 32'(broken), 32'd0);
    chk("rst_balanced", 32'(balanced), 32'd1);
    reset  = 1'b0;
    mon_en = 1'b1;

    // BEGIN then END held back-to-back, then END at depth 0 in uppercase,
    // then a BEGIN/END pair that cannot clear the sticky error.
    send(2'd0, 1'b0, 8'h00);
    send(2'd1, 1'b0, 8'h00);
    drain();
    send(2'd1, 1'b1, 8'h00);
    send(2'd0, 1'b0, 8'h00);
    send(2'd1, 1'b0, 8'h00);
    drain();
    chk("sticky_balanced", 32'(balanced), 32'd0);

    // Depth saturation: four BEGINs with a 2-bit counter.
    do_reset();
    repeat (4) send(2'd0, 1'b1, 8'h00);
    drain();
    chk("sat_depth", 32'(depth), 32'(MAXD));
    chk("sat_broken", 32'(broken), 32'd1);

    // FILL 'x', reserved code, FILL with a space character.
    do_reset();
    send(2'd2, 1'b1, 8'h78);
    send(2'd3, 1'b0, 8'h00);
    idle(3);
    send(2'd2, 1'b0, 8'h20);
    drain();
    chk("fill_depth", 32'(depth), 32'd0);

    // Randomised rounds, reset between rounds.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 8'h20 : 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
      end
      drain();
    end

    // Reset while the third character of a BEGIN is on the output.
    do_reset();
    drain();
    mon_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = 2'd0;
    upper     = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_char", 32'(out), 32'h67);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", 32'(out), 32'h20);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_broken", 32'(broken), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_depth", 32'(depth), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_token_emitter.md
# block_token_emitter

Transmit-side counterpart of the block checker. Accepts BEGIN / END / FILL commands over a valid/ready handshake and serialises each one as a space-terminated ASCII word, one character per cycle, in the format the checker consumes. Tracks nesting depth and reports the verdict a checker fed this stream would give. Used as a stimulus source in system benches and as the character source in the demo top.

## Interface
- `DEPTH_W`, default 8: width of the nesting-depth counter.
- `clk  in  1`: clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `cmd_valid  in  1`: a command is presented.
- `cmd  in  2`: command code; 0 = BEGIN, 1 = END, 2 = FILL, 3 = reserved.
- `upper  in  1`: case of emitted letters; 1 = uppercase, 0 = lowercase. Sampled at acceptance.
- `fill_char  in  8`: character emitted by FILL. Sampled at acceptance.
- `cmd_ready  out  1`: a command is accepted this cycle when `cmd_valid && cmd_ready`.
- `out  out  8`: emitted character, registered.
- `out_valid  out  1`: `out` carries a token character this cycle.
- `depth  out  DEPTH_W`: current nesting depth.
- `balanced  out  1`: high when `depth == 0` and `broken == 0`.
- `broken  out  1`: sticky flag; set on END at depth 0 or on BEGIN at maximum depth.

## Operation
- Token strings:
  - BEGIN emits `b e g i n` followed by a space (6 characters).
  - END emits `e n d` followed by a space (4 characters).
  - FILL emits `fill_char` followed by a space (2 characters).
  - When `upper` is 1, letters are ASCII uppercase (0x42 "B", etc.). `fill_char` is emitted verbatim.
- Reserved code 3: accepted and dropped. Nothing is emitted, there is no state change and no error.
- States: S_IDLE and S_EMIT.
  - S_IDLE: `cmd_ready = 1`, `out = 8'h20`, `out_valid = 0`.
  - Acceptance of a non-reserved command moves to S_EMIT. It latches the token, the case and `fill_char`, and clears index `idx`.
  - S_EMIT: `out` holds the character at `idx`, `idx` increments each cycle, and `out_valid = 1`.
  - The cycle that emits the trailing space is the last character. `cmd_ready = 1` in that cycle.
  - Accept in the last-character cycle: stay in S_EMIT, restart at `idx = 0` with the new token. Output is back-to-back with no gap.
  - No accept in the last-character cycle: return to S_IDLE.
- Depth and error update, applied at the edge ending the trailing-space cycle:
  - BEGIN: if `depth == 2^DEPTH_W - 1`, set `broken` and hold `depth`. Otherwise `depth + 1`.
  - END: if `depth == 0`, set `broken` and hold at 0. Otherwise `depth - 1`.
  - FILL: no change.
- `broken` is cleared only by reset. Once set, `balanced` stays 0. This mirrors the checker latching failure on a premature end.
- FILL with `fill_char == 8'h20` emits two spaces. It is legal and has no effect on depth.
- The output has no backpressure. The consumer samples `out` every cycle.

## Timing
- Reset values: `out = 8'h20`, `out_valid = 0`, `cmd_ready = 1`, state S_IDLE, `depth = 0`, `broken = 0`, `balanced = 1`.
- Command accepted at edge t: first character is valid in cycle t+1. A BEGIN occupies cycles t+1 through t+6.
- `depth`, `broken` and `balanced` change at the edge after the space is emitted, i.e. visible in cycle t+7 for a BEGIN. This aligns with when a checker fed `out` updates its result.
- Maximum throughput: one character per cycle, sustained across back-to-back tokens.
- Reset asserted mid-token: at the next edge the token is truncated and every output returns to its reset value. The partial word is not counted.
- `cmd_ready` is a combinational function of state and `idx` only. It never depends on `cmd_valid`.

## Structure
- Shared package holds:
  - command encodings CMD_BEGIN / CMD_END / CMD_FILL / CMD_RSVD;
  - ASCII constants: space 8'h20, and the case offset 8'h20;
  - token lengths 6 / 4 / 2.
- One sub-module, `token_rom`: purely combinational; maps (token, `idx`, `upper`, `fill_char`) to a character and a last flag. The FSM, `idx` counter, depth counter and flags stay in the top module.

## Test plan
- Reset, then BEGIN (`upper = 0`): `out` = 62 65 67 69 6E 20 over cycles 1–6 with `out_valid = 1`; `depth = 1` and `balanced = 0` from cycle 7.
- BEGIN, END held back-to-back with `cmd_valid` high: no gap; stream reads "begin end "; final `depth = 0`, `balanced = 1`, `cmd_ready` high in cycles 6 and 10.
- END at depth 0 (`upper = 1`): emits 45 4E 44 20; `broken = 1` and `depth = 0` from cycle 5; a following BEGIN, END still leaves `balanced = 0`.
- `DEPTH_W = 2`, four BEGINs: `depth` = 3 after the third; the fourth sets `broken`, `depth` stays 3.
- FILL with `fill_char = 8'h78`, then reserved code 3: emits 78 20; the reserved command is accepted with no output and `depth` unchanged.
- Reset at the third character of BEGIN: next cycle `out = 20`, `out_valid = 0`, `depth = 0`, `broken = 0`, `cmd_ready = 1`.
